// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles both requester ports (A: pipeline MEM stage, B: DMA/debug) and the
// single-ported data memory side of the arbiter.
//   a_*/b_*  : req/we/addr/wdata in, gnt/rvalid/rdata/err out (per port)
//   mem_*    : address/dataIn/memWrite/memRead out, mem_data in
// modport slave  : the arbiter's view
// modport master : the requesters' and memory's view
interface dmem_arbiter_if;
    logic        a_req;
    logic [1:0]  a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic [31:0] a_rdata;
    logic        a_err;

    logic        b_req;
    logic [1:0]  b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        b_err;

    logic [31:0] mem_address;
    logic [31:0] mem_dataIn;
    logic [1:0]  mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_data;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata, b_err,
        output mem_address, mem_dataIn, mem_memWrite, mem_memRead,
        input  mem_data
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata, b_err,
        input  mem_address, mem_dataIn, mem_memWrite, mem_memRead,
        output mem_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter in front of a single-ported data memory. Port A has
// priority; port B wins after STARVE_LIMIT consecutive losses. Each access
// takes one ACCESS cycle (gnt high, memory driven) followed by an rvalid
// pulse on the winning port.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dmem_arbiter_if.slave (ports A/B and memory side)
module dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  starve_reg, starve_next;
    logic        sel_b_reg, sel_b_next;
    logic [1:0]  we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        b_wins;

    logic        access;
    logic        in_range;
    logic        is_load;
    logic [31:0] rdata_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            starve_reg <= '0;
            sel_b_reg  <= 1'b0;
            we_reg     <= 2'b00;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
            sel_b_reg  <= sel_b_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        sel_b_next  = sel_b_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        b_wins      = 1'b0;
        case (state_reg)
            IDLE: begin
                b_wins = bus.b_req && (!bus.a_req || starve_reg == LIMIT);
                // The counter only survives an IDLE cycle when B is pending
                // and loses again; any B win or idle B clears it.
                if (bus.a_req && bus.b_req && !b_wins)
                    starve_next = (starve_reg >= LIMIT) ? LIMIT : starve_reg + 3'd1;
                else
                    starve_next = '0;
                if (bus.a_req || bus.b_req) begin
                    state_next = ACCESS;
                    sel_b_next = b_wins;
                    we_next    = b_wins ? bus.b_we    : bus.a_we;
                    addr_next  = b_wins ? bus.b_addr  : bus.a_addr;
                    wdata_next = b_wins ? bus.b_wdata : bus.a_wdata;
                end
            end
            ACCESS: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign access   = (state_reg == ACCESS);
    assign in_range = (addr_reg[31:ADDR_W] == '0);
    assign is_load  = (we_reg == 2'b00);

    // Address/data are presented straight from the latch so they only move
    // on entry to ACCESS; the strobes are qualified by state and range.
    assign bus.mem_address  = addr_reg;
    assign bus.mem_dataIn   = wdata_reg;
    assign bus.mem_memWrite = (access && in_range) ? we_reg : 2'b00;
    assign bus.mem_memRead  = access && in_range && is_load;

    assign bus.a_gnt = access && !sel_b_reg;
    assign bus.b_gnt = access &&  sel_b_reg;

    assign rdata_value = (in_range && is_load) ? bus.mem_data : 32'd0;

    // Per-port completion registers; they only update for the port that owns
    // the finishing access, so the other port's rdata/err hold.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_port
        localparam logic PORT_B = (gi == 1);
        logic        done;
        logic        rvalid_reg;
        logic [31:0] rdata_reg;
        logic        err_reg;

        assign done = access && (sel_b_reg == PORT_B);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
                err_reg    <= 1'b0;
            end else begin
                rvalid_reg <= done;
                if (done) begin
                    rdata_reg <= rdata_value;
                    err_reg   <= !in_range;
                end
            end
        end
    end

    assign bus.a_rvalid = gen_port[0].rvalid_reg;
    assign bus.a_rdata  = gen_port[0].rdata_reg;
    assign bus.a_err    = gen_port[0].err_reg;
    assign bus.b_rvalid = gen_port[1].rvalid_reg;
    assign bus.b_rdata  = gen_port[1].rdata_reg;
    assign bus.b_err    = gen_port[1].err_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a 1024-word behavioural memory that
// honours the store-word/half/byte codes.
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dmem_arbiter_if bus();

    dmem_arbiter #(.ADDR_W(10), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [1024];
    assign bus.mem_data = mem[bus.mem_address[9:0]];

    always @(posedge clk) begin
        case (bus.mem_memWrite)
            2'b01: mem[bus.mem_address[9:0]]        <= bus.mem_dataIn;
            2'b10: mem[bus.mem_address[9:0]][15:0]  <= bus.mem_dataIn[15:0];
            2'b11: mem[bus.mem_address[9:0]][7:0]   <= bus.mem_dataIn[7:0];
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_a(input logic req, input logic [1:0] we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        if (req) $display("txn A we=%b addr=%h wdata=%h", we, addr, wdata);
    endtask

    task automatic drive_b(input logic req, input logic [1:0] we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        if (req) $display("txn B we=%b addr=%h wdata=%h", we, addr, wdata);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        drive_b(1'b0, 2'b00, 32'd0, 32'd0);
        #12;
        checks++; if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt_rvalid: got %b want 0000", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}); end
        checks++; if ({bus.a_err, bus.b_err, bus.a_rdata, bus.b_rdata} !== 66'd0) begin
            errors++; $display("FAIL reset_err_rdata: got %h want 0", {bus.a_err, bus.b_err, bus.a_rdata, bus.b_rdata}); end
        checks++; if ({bus.mem_address, bus.mem_dataIn, bus.mem_memWrite, bus.mem_memRead} !== 67'd0) begin
            errors++; $display("FAIL reset_mem: got %h want 0", {bus.mem_address, bus.mem_dataIn, bus.mem_memWrite, bus.mem_memRead}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts right after reset release: the first edge must accept the request.
    task automatic test_store_load;
        drive_a(1'b1, 2'b01, 32'd5, 32'hDEADBEEF);
        @(posedge clk); #1;
        checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
            errors++; $display("FAIL sw_gnt: got %b want 10", {bus.a_gnt, bus.b_gnt}); end
        checks++; if (bus.mem_memWrite !== 2'b01 || bus.mem_memRead !== 1'b0) begin
            errors++; $display("FAIL sw_strobe: got we=%b rd=%b want we=01 rd=0", bus.mem_memWrite, bus.mem_memRead); end
        checks++; if (bus.mem_address !== 32'd5 || bus.mem_dataIn !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_bus: got addr=%h data=%h want 5/deadbeef", bus.mem_address, bus.mem_dataIn); end
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_err !== 1'b0 || bus.a_rdata !== 32'd0) begin
            errors++; $display("FAIL sw_rvalid: got v=%b e=%b d=%h want 1/0/0", bus.a_rvalid, bus.a_err, bus.a_rdata); end
        checks++; if (bus.mem_memWrite !== 2'b00 || bus.a_gnt !== 1'b0) begin
            errors++; $display("FAIL sw_after: got we=%b gnt=%b want 00/0", bus.mem_memWrite, bus.a_gnt); end
        drive_a(1'b1, 2'b00, 32'd5, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_gnt !== 1'b1 || bus.mem_memRead !== 1'b1 || bus.mem_memWrite !== 2'b00) begin
            errors++; $display("FAIL lw_gnt: got gnt=%b rd=%b we=%b want 1/1/00", bus.a_gnt, bus.mem_memRead, bus.mem_memWrite); end
        checks++; if (bus.a_rvalid !== 1'b0) begin
            errors++; $display("FAIL lw_rvalid_early: got %b want 0", bus.a_rvalid); end
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hDEADBEEF || bus.a_err !== 1'b0) begin
            errors++; $display("FAIL lw_data: got v=%b d=%h e=%b want 1/deadbeef/0", bus.a_rvalid, bus.a_rdata, bus.a_err); end
        checks++; if (bus.mem_memRead !== 1'b0) begin
            errors++; $display("FAIL lw_rd_after: got %b want 0", bus.mem_memRead); end
        @(posedge clk); #1;
        checks++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_hold: got v=%b d=%h want 0/deadbeef", bus.a_rvalid, bus.a_rdata); end
    endtask

    // Both ports request continuously: expected winners A,A,A,A,B,A.
    task automatic test_starve;
        logic exp_b;
        drive_a(1'b1, 2'b00, 32'd5, 32'd0);
        drive_b(1'b1, 2'b00, 32'd5, 32'd0);
        for (int i = 0; i < 6; i++) begin
            exp_b = (i == 4);
            @(posedge clk); #1;
            checks++; if ({bus.a_gnt, bus.b_gnt} !== {!exp_b, exp_b}) begin
                errors++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, {bus.a_gnt, bus.b_gnt}, {!exp_b, exp_b}); end
            @(posedge clk); #1;
            checks++; if ({bus.a_rvalid, bus.b_rvalid} !== {!exp_b, exp_b}) begin
                errors++; $display("FAIL starve_rvalid[%0d]: got %b want %b", i, {bus.a_rvalid, bus.b_rvalid}, {!exp_b, exp_b}); end
        end
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        drive_b(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic test_store_byte;
        drive_b(1'b1, 2'b01, 32'd7, 32'h11223344);
        @(posedge clk); #1;
        drive_b(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'd0 || bus.a_rvalid !== 1'b0) begin
            errors++; $display("FAIL sb_pre_rvalid: got bv=%b bd=%h av=%b want 1/0/0", bus.b_rvalid, bus.b_rdata, bus.a_rvalid); end
        drive_b(1'b1, 2'b11, 32'd7, 32'h000000AA);
        @(posedge clk); #1;
        checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b01 || bus.mem_memWrite !== 2'b11) begin
            errors++; $display("FAIL sb_strobe: got gnt=%b we=%b want 01/11", {bus.a_gnt, bus.b_gnt}, bus.mem_memWrite); end
        drive_b(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        drive_b(1'b1, 2'b00, 32'd7, 32'd0);
        @(posedge clk); #1;
        drive_b(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'h112233AA) begin
            errors++; $display("FAIL sb_load: got v=%b d=%h want 1/112233aa", bus.b_rvalid, bus.b_rdata); end
        checks++; if (bus.a_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sb_a_hold: got %h want deadbeef", bus.a_rdata); end
    endtask

    task automatic test_out_of_range;
        drive_a(1'b1, 2'b00, 32'h400, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_gnt !== 1'b1 || bus.mem_memRead !== 1'b0 || bus.mem_memWrite !== 2'b00) begin
            errors++; $display("FAIL oor_ld_strobe: got gnt=%b rd=%b we=%b want 1/0/00", bus.a_gnt, bus.mem_memRead, bus.mem_memWrite); end
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_err !== 1'b1 || bus.a_rdata !== 32'd0) begin
            errors++; $display("FAIL oor_ld_resp: got v=%b e=%b d=%h want 1/1/0", bus.a_rvalid, bus.a_err, bus.a_rdata); end
        drive_a(1'b1, 2'b01, 32'h8000_0005, 32'h55555555);
        @(posedge clk); #1;
        checks++; if (bus.mem_memWrite !== 2'b00) begin
            errors++; $display("FAIL oor_st_strobe: got %b want 00", bus.mem_memWrite); end
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        drive_a(1'b1, 2'b00, 32'h3FF, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.mem_memRead !== 1'b1) begin
            errors++; $display("FAIL top_word_rd: got %b want 1", bus.mem_memRead); end
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_err !== 1'b0) begin
            errors++; $display("FAIL top_word_err: got v=%b e=%b want 1/0", bus.a_rvalid, bus.a_err); end
        drive_a(1'b1, 2'b00, 32'd5, 32'd0);
        @(posedge clk); #1;
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL oor_no_write: got %h want deadbeef", bus.a_rdata); end
    endtask

    task automatic test_reset_mid_access;
        drive_a(1'b1, 2'b01, 32'd9, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        drive_a(1'b1, 2'b01, 32'd9, 32'h12345678);
        @(posedge clk); #1;
        checks++; if (bus.mem_memWrite !== 2'b01) begin
            errors++; $display("FAIL mid_pre: got %b want 01", bus.mem_memWrite); end
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_memWrite !== 2'b00 || bus.a_gnt !== 1'b0 || bus.mem_address !== 32'd0) begin
            errors++; $display("FAIL mid_async: got we=%b gnt=%b addr=%h want 00/0/0", bus.mem_memWrite, bus.a_gnt, bus.mem_address); end
        @(posedge clk); #1;
        checks++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'd0) begin
            errors++; $display("FAIL mid_no_rvalid: got v=%b d=%h want 0/0", bus.a_rvalid, bus.a_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1'b1, 2'b00, 32'd9, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_gnt !== 1'b1 || bus.mem_memRead !== 1'b1) begin
            errors++; $display("FAIL mid_next_gnt: got gnt=%b rd=%b want 1/1", bus.a_gnt, bus.mem_memRead); end
        drive_a(1'b0, 2'b00, 32'd0, 32'd0);
        @(posedge clk); #1;
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL mid_next_data: got v=%b d=%h want 1/cafef00d", bus.a_rvalid, bus.a_rdata); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_store_load();
        test_starve();
        test_store_byte();
        test_out_of_range();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address width of the data memory (1024 words).
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive arbitration losses after which port B wins.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 a_req  in  1  port A (pipeline MEM stage) request, held with command until a_gnt.
REQ-006 a_we  in  2  port A op: 00 load, 01 store word, 10 store half [15:0], 11 store byte [7:0].
REQ-007 a_addr  in  32  port A word address.
REQ-008 a_wdata  in  32  port A store data.
REQ-009 a_gnt  out  1  one-cycle pulse: port A command accepted.
REQ-010 a_rvalid  out  1  one-cycle pulse: port A access complete.
REQ-011 a_rdata  out  32  port A load data, valid with a_rvalid.
REQ-012 a_err  out  1  out-of-range flag, valid with a_rvalid.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: port B (DMA/debug), same widths and meaning as port A.
REQ-014 mem_address  out  32  to memory address.
REQ-015 mem_dataIn  out  32  to memory write data.
REQ-016 mem_memWrite  out  2  to memory store code (encoding as REQ-006).
REQ-017 mem_memRead  out  1  to memory read enable.
REQ-018 mem_data  in  32  memory read data, combinational from mem_address.

Function
REQ-019 FSM states IDLE and ACCESS; IDLE -> ACCESS when any req sampled high; ACCESS -> IDLE unconditionally after one cycle.
REQ-020 In IDLE, single request: that port wins; both requesting: A wins unless starve count == STARVE_LIMIT, then B wins.
REQ-021 Starve counter (3 bits): +1 when A wins with b_req high; cleared on B win or when b_req sampled low in IDLE; saturates at STARVE_LIMIT.
REQ-022 On the IDLE->ACCESS edge: latch winner's we/addr/wdata and port id; winner's gnt high for exactly the ACCESS cycle; loser's gnt stays 0.
REQ-023 During ACCESS only: mem_memWrite = latched we (00 for loads), mem_memRead = 1 iff load and in range.
REQ-024 Outside ACCESS: mem_memWrite = 00, mem_memRead = 0; mem_address/mem_dataIn hold latched values, changing only on entry to ACCESS.
REQ-025 Out of range (addr[31:ADDR_W] != 0): mem_memWrite forced 00, mem_memRead 0, err = 1, rdata = 0.
REQ-026 On ACCESS->IDLE edge: winner's rvalid pulses one cycle; rdata = mem_data for in-range load, 0 for stores/errors.
REQ-027 Latency: req sampled cycle N -> gnt cycle N+1 -> rvalid/rdata cycle N+2; max throughput one access per 2 cycles.
REQ-028 req held high during ACCESS is ignored; requester drops req after gnt or it is treated as a new request at N+2.
REQ-029 rdata/err hold last values between rvalid pulses; rvalid never high on both ports in the same cycle.

Reset
REQ-030 rst_n low: state IDLE, starve counter 0, all gnt/rvalid/err 0, rdata 0, mem_* outputs 0, immediately and asynchronously.
REQ-031 Reset during ACCESS drops the access: mem_memWrite drops to 00 at once, no rvalid is issued.
REQ-032 First request accepted on the first rising edge with rst_n high.

Verification
REQ-033 A store word addr 5 data 0xDEADBEEF, then A load addr 5 -> a_gnt at N+1, mem_memWrite 01 one cycle; load a_rvalid at N+2 with a_rdata 0xDEADBEEF.
REQ-034 A and B both held requesting continuously -> grant order A,A,A,A,B,A,... (B wins after 4 losses).
REQ-035 B store byte 0x000000AA to addr 7 holding 0x11223344 -> mem_memWrite 11; subsequent load returns 0x112233AA.
REQ-036 A load addr 0x400 -> mem_memRead 0, mem_memWrite 00, a_rvalid with a_err 1, a_rdata 0.
REQ-037 rst_n low mid-ACCESS of store to addr 9 -> outputs 0 at once, no rvalid, next request served normally after release.
